// File: rtl/vga_timing_generator.sv
// Raster timing for the pixel pipeline: pixel-clock enable, free-running h/v counters,
// zero-skew registered syncs, display_on, and line/frame start strobes.
module vga_timing_generator #(
  parameter int unsigned CLK_DIV      = 5,
  parameter int unsigned H_VISIBLE    = 640,
  parameter int unsigned H_SYNC_START = 656,
  parameter int unsigned H_SYNC_END   = 751,
  parameter int unsigned H_TOTAL      = 800,
  parameter int unsigned V_VISIBLE    = 480,
  parameter int unsigned V_SYNC_START = 490,
  parameter int unsigned V_SYNC_END   = 491,
  parameter int unsigned V_TOTAL      = 525,
  parameter bit          SYNC_ACT     = 1'b1
) (
  input  logic       clock_in,
  input  logic       reset_in,
  output logic       pix_tick_out,
  output logic [9:0] hpos_out,
  output logic [9:0] vpos_out,
  output logic       hsync_out,
  output logic       vsync_out,
  output logic       display_on_out,
  output logic       line_start_out,
  output logic       frame_start_out
);

  localparam int unsigned POS_W = 10;
  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [POS_W-1:0] H_LAST   = POS_W'(H_TOTAL - 1);
  localparam logic [POS_W-1:0] V_LAST   = POS_W'(V_TOTAL - 1);
  localparam logic [POS_W-1:0] H_VIS    = POS_W'(H_VISIBLE);
  localparam logic [POS_W-1:0] V_VIS    = POS_W'(V_VISIBLE);
  localparam logic [POS_W-1:0] H_SS     = POS_W'(H_SYNC_START);
  localparam logic [POS_W-1:0] H_SE     = POS_W'(H_SYNC_END);
  localparam logic [POS_W-1:0] V_SS     = POS_W'(V_SYNC_START);
  localparam logic [POS_W-1:0] V_SE     = POS_W'(V_SYNC_END);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             pix_tick_q, pix_tick_d;
  logic [POS_W-1:0] hpos_q, hpos_d;
  logic [POS_W-1:0] vpos_q, vpos_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             display_on_q, display_on_d;
  logic             line_start_q, line_start_d;
  logic             frame_start_q, frame_start_d;

  // Counters step on the edge that closes a tick cycle; decodes use the next position
  // so syncs, display_on and strobes line up with hpos/vpos on every cycle.
  always_comb begin
    pix_tick_d = (div_cnt_q == DIV_LAST);
    div_cnt_d  = pix_tick_d ? '0 : div_cnt_q + DIV_W'(1);
    hpos_d     = hpos_q;
    vpos_d     = vpos_q;

    if (pix_tick_q) begin
      if (hpos_q == H_LAST) begin
        hpos_d = '0;
        vpos_d = (vpos_q == V_LAST) ? '0 : vpos_q + POS_W'(1);
      end else begin
        hpos_d = hpos_q + POS_W'(1);
      end
    end

    hsync_d       = ((hpos_d >= H_SS) && (hpos_d <= H_SE)) ? SYNC_ACT : ~SYNC_ACT;
    vsync_d       = ((vpos_d >= V_SS) && (vpos_d <= V_SE)) ? SYNC_ACT : ~SYNC_ACT;
    display_on_d  = (hpos_d < H_VIS) && (vpos_d < V_VIS);
    line_start_d  = pix_tick_d && (hpos_d == '0);
    frame_start_d = line_start_d && (vpos_d == '0);
  end

  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      div_cnt_q     <= '0;
      pix_tick_q    <= 1'b0;
      hpos_q        <= '0;
      vpos_q        <= '0;
      hsync_q       <= ~SYNC_ACT;
      vsync_q       <= ~SYNC_ACT;
      display_on_q  <= 1'b1;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      div_cnt_q     <= div_cnt_d;
      pix_tick_q    <= pix_tick_d;
      hpos_q        <= hpos_d;
      vpos_q        <= vpos_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      display_on_q  <= display_on_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign pix_tick_out    = pix_tick_q;
  assign hpos_out        = hpos_q;
  assign vpos_out        = vpos_q;
  assign hsync_out       = hsync_q;
  assign vsync_out       = vsync_q;
  assign display_on_out  = display_on_q;
  assign line_start_out  = line_start_q;
  assign frame_start_out = frame_start_q;

endmodule

// File: tb/tb_vga_timing_generator.sv
// Bench for vga_timing_generator: default, CLK_DIV=1, and two small-geometry instances
// (active-high / active-low syncs) checked against a tick-count raster model.
module tb_vga_timing_generator;

  typedef struct packed {
    logic       tick;
    logic [9:0] h;
    logic [9:0] v;
    logic       hs;
    logic       vs;
    logic       de;
    logic       ls;
    logic       fs;
  } exp_t;

  localparam int NI = 4;
  localparam int D   [NI] = '{5, 1, 3, 3};
  localparam int HV  [NI] = '{640, 640, 16, 16};
  localparam int HSS [NI] = '{656, 656, 18, 18};
  localparam int HSE [NI] = '{751, 751, 21, 21};
  localparam int HT  [NI] = '{800, 800, 24, 24};
  localparam int VV  [NI] = '{480, 480, 10, 10};
  localparam int VSS [NI] = '{490, 490, 12, 12};
  localparam int VSE [NI] = '{491, 491, 13, 13};
  localparam int VT  [NI] = '{525, 525, 15, 15};
  localparam bit ACT [NI] = '{1'b1, 1'b1, 1'b1, 1'b0};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  int         cyc = 0;
  int         n_chk = 0;
  int         n_fail = 0;

  logic       tick_w [NI];
  logic [9:0] h_w    [NI];
  logic [9:0] v_w    [NI];
  logic       hs_w   [NI];
  logic       vs_w   [NI];
  logic       de_w   [NI];
  logic       ls_w   [NI];
  logic       fs_w   [NI];
  exp_t       obs    [NI];

  always #5 clk = ~clk;

  // Clocks since the last edge that sampled reset high.
  always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

  vga_timing_generator u_def (
    .clock_in(clk), .reset_in(rst), .pix_tick_out(tick_w[0]), .hpos_out(h_w[0]),
    .vpos_out(v_w[0]), .hsync_out(hs_w[0]), .vsync_out(vs_w[0]), .display_on_out(de_w[0]),
    .line_start_out(ls_w[0]), .frame_start_out(fs_w[0]));

  vga_timing_generator #(.CLK_DIV(1)) u_d1 (
    .clock_in(clk), .reset_in(rst), .pix_tick_out(tick_w[1]), .hpos_out(h_w[1]),
    .vpos_out(v_w[1]), .hsync_out(hs_w[1]), .vsync_out(vs_w[1]), .display_on_out(de_w[1]),
    .line_start_out(ls_w[1]), .frame_start_out(fs_w[1]));

  vga_timing_generator #(.CLK_DIV(3), .H_VISIBLE(16), .H_SYNC_START(18), .H_SYNC_END(21),
    .H_TOTAL(24), .V_VISIBLE(10), .V_SYNC_START(12), .V_SYNC_END(13), .V_TOTAL(15),
    .SYNC_ACT(1'b1)) u_sm (
    .clock_in(clk), .reset_in(rst), .pix_tick_out(tick_w[2]), .hpos_out(h_w[2]),
    .vpos_out(v_w[2]), .hsync_out(hs_w[2]), .vsync_out(vs_w[2]), .display_on_out(de_w[2]),
    .line_start_out(ls_w[2]), .frame_start_out(fs_w[2]));

  vga_timing_generator #(.CLK_DIV(3), .H_VISIBLE(16), .H_SYNC_START(18), .H_SYNC_END(21),
    .H_TOTAL(24), .V_VISIBLE(10), .V_SYNC_START(12), .V_SYNC_END(13), .V_TOTAL(15),
    .SYNC_ACT(1'b0)) u_smn (
    .clock_in(clk), .reset_in(rst), .pix_tick_out(tick_w[3]), .hpos_out(h_w[3]),
    .vpos_out(v_w[3]), .hsync_out(hs_w[3]), .vsync_out(vs_w[3]), .display_on_out(de_w[3]),
    .line_start_out(ls_w[3]), .frame_start_out(fs_w[3]));

  for (genvar g = 0; g < NI; g++) begin : g_obs
    assign obs[g] = {tick_w[g], h_w[g], v_w[g], hs_w[g], vs_w[g], de_w[g], ls_w[g], fs_w[g]};
  end

  // Raster model: tick every D clocks after release; position = ticks already consumed.
  function automatic exp_t expected(int i, int c);
    exp_t e;
    int p, h, v;
    p      = (c == 0) ? 0 : (c - 1) / D[i];
    h      = p % HT[i];
    v      = (p / HT[i]) % VT[i];
    e.tick = (c > 0) && (c % D[i] == 0);
    e.h    = 10'(h);
    e.v    = 10'(v);
    e.hs   = (h >= HSS[i] && h <= HSE[i]) ? ACT[i] : !ACT[i];
    e.vs   = (v >= VSS[i] && v <= VSE[i]) ? ACT[i] : !ACT[i];
    e.de   = (h < HV[i]) && (v < VV[i]);
    e.ls   = e.tick && (h == 0);
    e.fs   = e.ls && (v == 0);
    return e;
  endfunction

  function automatic exp_t reset_state(int i);
    exp_t e;
    e    = '0;
    e.hs = !ACT[i];
    e.vs = !ACT[i];
    e.de = 1'b1;
    return e;
  endfunction

  task automatic test_reset();
    int hold, n;
    bit found;
    rst  = 1'b1;
    hold = 3 + $urandom_range(0, 2);
    repeat (hold) @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      n_chk++;
      if (obs[i] !== reset_state(i)) begin
        n_fail++;
        $display("FAIL reset_state inst=%0d got=%h exp=%h", i, obs[i], reset_state(i));
      end
    end
    rst   = 1'b0;
    n     = 0;
    found = 1'b0;
    while (!found && n < 20) begin
      @(negedge clk);
      n++;
      for (int i = 0; i < NI; i++) begin
        n_chk++;
        if (obs[i] !== expected(i, cyc)) begin
          n_fail++;
          $display("FAIL reset_release inst=%0d cyc=%0d got=%h exp=%h", i, cyc, obs[i], expected(i, cyc));
        end
      end
      if (n == 1) begin
        n_chk++;
        if (tick_w[1] !== 1'b1 || fs_w[1] !== 1'b1) begin
          n_fail++;
          $display("FAIL first_tick_div1 got tick=%b fs=%b exp 1 1", tick_w[1], fs_w[1]);
        end
      end
      if (tick_w[0] === 1'b1) found = 1'b1;
    end
    n_chk++;
    if (!found || n != 5 || fs_w[0] !== 1'b1 || ls_w[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL first_tick_latency got=%0d fs=%b ls=%b exp=5 1 1", n, fs_w[0], ls_w[0]);
    end
  endtask

  task automatic test_divider();
    int last, cycles;
    last   = -1;
    cycles = $urandom_range(40, 80);
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
        n_chk++;
        if (obs[i] !== expected(i, cyc)) begin
          n_fail++;
          $display("FAIL divider_model inst=%0d cyc=%0d got=%h exp=%h", i, cyc, obs[i], expected(i, cyc));
        end
      end
      if (tick_w[0] === 1'b1) begin
        if (last >= 0) begin
          n_chk++;
          if (cyc - last != 5) begin
            n_fail++;
            $display("FAIL tick_period got=%0d exp=5", cyc - last);
          end
        end
        last = cyc;
      end
      n_chk++;
      if (tick_w[1] !== 1'b1) begin
        n_fail++;
        $display("FAIL tick_div1 cyc=%0d got=%b exp=1", cyc, tick_w[1]);
      end
    end
  endtask

  task automatic test_hsync_edges();
    int hits, k;
    hits = 0;
    k    = 0;
    while (hits < 6 && k < 5000) begin
      @(negedge clk);
      k++;
      for (int i = 0; i < NI; i++) begin
        n_chk++;
        if (obs[i] !== expected(i, cyc)) begin
          n_fail++;
          $display("FAIL hsync_model inst=%0d cyc=%0d got=%h exp=%h", i, cyc, obs[i], expected(i, cyc));
        end
      end
      if (tick_w[0] === 1'b1 && v_w[0] == 10'd0) begin
        if (h_w[0] == 10'd655 || h_w[0] == 10'd752) begin
          hits++;
          n_chk++;
          if (hs_w[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL hsync_edge h=%0d got=%b exp=0", h_w[0], hs_w[0]);
          end
        end
        if (h_w[0] == 10'd656 || h_w[0] == 10'd751) begin
          hits++;
          n_chk++;
          if (hs_w[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL hsync_edge h=%0d got=%b exp=1", h_w[0], hs_w[0]);
          end
        end
        if (h_w[0] == 10'd639 || h_w[0] == 10'd640) begin
          hits++;
          n_chk++;
          if (de_w[0] !== (h_w[0] == 10'd639)) begin
            n_fail++;
            $display("FAIL display_edge h=%0d got=%b exp=%b", h_w[0], de_w[0], h_w[0] == 10'd639);
          end
        end
      end
    end
    n_chk++;
    if (hits != 6) begin
      n_fail++;
      $display("FAIL hsync_edges_seen got=%0d exp=6", hits);
    end
  endtask

  task automatic test_wrap();
    bit pend0, pend2, done0, done2;
    int prev_v, k;
    pend0 = 0; pend2 = 0; done0 = 0; done2 = 0; prev_v = 0; k = 0;
    while (!(done0 && done2) && k < 6000) begin
      @(negedge clk);
      k++;
      for (int i = 0; i < NI; i++) begin
        n_chk++;
        if (obs[i] !== expected(i, cyc)) begin
          n_fail++;
          $display("FAIL wrap_model inst=%0d cyc=%0d got=%h exp=%h", i, cyc, obs[i], expected(i, cyc));
        end
      end
      if (tick_w[0] === 1'b1 && !done0) begin
        if (pend0) begin
          done0 = 1;
          n_chk++;
          if (h_w[0] != 10'd0 || int'(v_w[0]) != (prev_v + 1) % 525 || ls_w[0] !== 1'b1 ||
              fs_w[0] !== ((prev_v + 1) % 525 == 0)) begin
            n_fail++;
            $display("FAIL line_wrap got=(%0d,%0d) ls=%b fs=%b exp=(0,%0d)", h_w[0], v_w[0],
                     ls_w[0], fs_w[0], (prev_v + 1) % 525);
          end
        end else if (h_w[0] == 10'd799) begin
          pend0  = 1;
          prev_v = int'(v_w[0]);
        end
      end
      if (tick_w[2] === 1'b1 && !done2) begin
        if (pend2) begin
          done2 = 1;
          n_chk++;
          if (h_w[2] != 10'd0 || v_w[2] != 10'd0 || fs_w[2] !== 1'b1 || ls_w[2] !== 1'b1) begin
            n_fail++;
            $display("FAIL frame_wrap got=(%0d,%0d) fs=%b ls=%b exp=(0,0) 1 1", h_w[2], v_w[2],
                     fs_w[2], ls_w[2]);
          end
        end else if (h_w[2] == 10'd23 && v_w[2] == 10'd14) begin
          pend2 = 1;
        end
      end
    end
    n_chk++;
    if (!(done0 && done2)) begin
      n_fail++;
      $display("FAIL wrap_timeout got=%0d%0d exp=11", done0, done2);
    end
  endtask

  task automatic test_full_frame();
    int ticks, lines, hs_t, vs_t, de_t, fs_n, vs_lines, vs_sum;
    ticks = 0; lines = 0; hs_t = 0; vs_t = 0; de_t = 0; fs_n = 0; vs_lines = 0; vs_sum = 0;
    rst = 1'b1;
    repeat (2 + $urandom_range(0, 3)) @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3 * 24 * 15; k++) begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
        n_chk++;
        if (obs[i] !== expected(i, cyc)) begin
          n_fail++;
          $display("FAIL frame_model inst=%0d cyc=%0d got=%h exp=%h", i, cyc, obs[i], expected(i, cyc));
        end
      end
      n_chk++;
      if (hs_w[3] !== ~hs_w[2] || vs_w[3] !== ~vs_w[2] || tick_w[3] !== tick_w[2] ||
          h_w[3] !== h_w[2] || v_w[3] !== v_w[2] || de_w[3] !== de_w[2] ||
          ls_w[3] !== ls_w[2] || fs_w[3] !== fs_w[2]) begin
        n_fail++;
        $display("FAIL sync_polarity cyc=%0d got=%h exp_inverted_of=%h", cyc, obs[3], obs[2]);
      end
      if (tick_w[2] === 1'b1) begin
        ticks++;
        if (hs_w[2] === 1'b1) hs_t++;
        if (vs_w[2] === 1'b1) vs_t++;
        if (de_w[2] === 1'b1) de_t++;
        if (fs_w[2] === 1'b1) fs_n++;
        if (ls_w[2] === 1'b1) begin
          lines++;
          if (vs_w[2] === 1'b1) begin
            vs_lines++;
            vs_sum += int'(v_w[2]);
          end
        end
      end
    end
    n_chk++;
    if (ticks != 24 * 15 || lines != 15 || fs_n != 1) begin
      n_fail++;
      $display("FAIL frame_counts got=%0d/%0d/%0d exp=360/15/1", ticks, lines, fs_n);
    end
    n_chk++;
    if (hs_t != 4 * 15 || vs_t != 2 * 24 || de_t != 16 * 10) begin
      n_fail++;
      $display("FAIL frame_sync_counts got=%0d/%0d/%0d exp=60/48/160", hs_t, vs_t, de_t);
    end
    n_chk++;
    if (vs_lines != 2 || vs_sum != 12 + 13) begin
      n_fail++;
      $display("FAIL vsync_lines got=%0d sum=%0d exp=2 sum=25", vs_lines, vs_sum);
    end
  endtask

  task automatic test_mid_reset();
    int first;
    repeat ($urandom_range(20, 300)) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < NI; i++) begin
      n_chk++;
      if (obs[i] !== reset_state(i)) begin
        n_fail++;
        $display("FAIL mid_reset_state inst=%0d got=%h exp=%h", i, obs[i], reset_state(i));
      end
    end
    first = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
        n_chk++;
        if (obs[i] !== expected(i, cyc)) begin
          n_fail++;
          $display("FAIL mid_reset_model inst=%0d cyc=%0d got=%h exp=%h", i, cyc, obs[i], expected(i, cyc));
        end
      end
      if (tick_w[0] === 1'b1 && first == 0) first = k;
    end
    n_chk++;
    if (first != 5) begin
      n_fail++;
      $display("FAIL mid_reset_resume got=%0d exp=5", first);
    end
  endtask

  initial begin
    test_reset();
    test_divider();
    test_hsync_edges();
    test_wrap();
    test_full_frame();
    test_mid_reset();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
